// File: rtl/latch_readout_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// latch_readout_arbiter_pkg
// Shared definitions for the latch readout arbiter:
//   - arbState_t  : frame FSM state encoding
//   - HDR_SYNC    : sync nibble at the top of every header word
//   - CH_ID_1/2   : channel identifiers carried in the header (one-hot)
//   - makeHeader  : assembles the 32-bit header word
// -----------------------------------------------------------------------------
package latch_readout_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_LO   = 3'd2,
        ST_HI   = 3'd3,
        ST_ACK  = 3'd4,
        ST_CLR  = 3'd5
    } arbState_t;

    localparam logic [3:0] HDR_SYNC = 4'hA;
    localparam logic [1:0] CH_ID_1  = 2'b01;
    localparam logic [1:0] CH_ID_2  = 2'b10;

    // Header layout: sync[31:28], 2'b00, channel id[25:24], 8'h00, seq[15:0]
    function automatic logic [31:0] makeHeader(input logic [1:0]  chId,
                                               input logic [15:0] seq);
        return {HDR_SYNC, 2'b00, chId, 8'h00, seq};
    endfunction

endpackage

// File: rtl/latch_readout_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-requester round-robin arbiter with a last-grant pointer.
// After reset requester 0 is preferred. When both request, the one that was
// not granted last wins. The pointer only moves when iAdvance is high and a
// grant is actually issued.
// Ports:
//   iCLK      clock
//   iRSTn     asynchronous active-low reset
//   iReq      request vector (bit0 = requester 0, bit1 = requester 1)
//   iAdvance  grant is being consumed this cycle; update the pointer
//   oGrant    one-hot grant (combinational from iReq and the pointer)
// -----------------------------------------------------------------------------
module rr_arb2 (
    input  logic       iCLK,
    input  logic       iRSTn,
    input  logic [1:0] iReq,
    input  logic       iAdvance,
    output logic [1:0] oGrant
);

    // 1 = requester 1 was granted last (so requester 0 is preferred next)
    logic lastWasOneReg;

    always_comb begin
        oGrant = 2'b00;
        unique case (iReq)
            2'b01:   oGrant = 2'b01;
            2'b10:   oGrant = 2'b10;
            2'b11:   oGrant = lastWasOneReg ? 2'b01 : 2'b10;
            default: oGrant = 2'b00;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            lastWasOneReg <= 1'b1;
        end else if (iAdvance && (oGrant != 2'b00)) begin
            lastWasOneReg <= oGrant[1];
        end
    end

endmodule

// File: rtl/latch_readout_arbiter.sv
// -----------------------------------------------------------------------------
// latch_readout_arbiter
// Drains two latched 64-bit timestamp channels into a single 32-bit word
// stream. Each sample is framed as header / low word / high word. Once the
// high word is accepted the channel's latch-reset pulse is issued and the
// arbiter waits for the channel's ready flag to drop, flagging a sticky error
// if it does not drop within pCLR_TIMEOUT cycles.
// Ports:
//   iCLK, iRSTn          clock, asynchronous active-low reset
//   iEN                  allow new grants (an in-flight frame always completes)
//   iRdy1, i1Lo, i1Hi    channel 1 ready flag and latched value
//   iRdy2, i2Lo, i2Hi    channel 2 ready flag and latched value
//   oResetLatch1/2       one-cycle latch release pulses
//   oDATA, oVALID, iREADY  word stream (valid/ready handshake)
//   oERR                 sticky clear-timeout flags (bit0 = ch1, bit1 = ch2)
//   oBUSY                FSM is not idle
// -----------------------------------------------------------------------------
module latch_readout_arbiter
    import latch_readout_arbiter_pkg::*;
#(
    parameter int pSEQ_W       = 16,
    parameter int pCLR_TIMEOUT = 15
) (
    input  logic        iCLK,
    input  logic        iRSTn,
    input  logic        iEN,
    input  logic        iRdy1,
    input  logic [31:0] i1Lo,
    input  logic [31:0] i1Hi,
    input  logic        iRdy2,
    input  logic [31:0] i2Lo,
    input  logic [31:0] i2Hi,
    output logic        oResetLatch1,
    output logic        oResetLatch2,
    output logic [31:0] oDATA,
    output logic        oVALID,
    input  logic        iREADY,
    output logic [1:0]  oERR,
    output logic        oBUSY
);

    localparam int CNT_W = $clog2(pCLR_TIMEOUT + 1);

    arbState_t          stateReg, stateNext;

    logic [1:0]         rdyVec;
    logic [1:0]         armedReg, armedNext;
    logic [1:0]         eligible;
    logic [1:0]         grant;
    logic               grantNow;

    logic [1:0]         chReg;          // one-hot id of the channel being served
    logic [1:0]         chSel;          // id the next header word should carry
    logic [63:0]        snapReg;
    logic [pSEQ_W-1:0]  seqReg;
    logic [15:0]        seqWide;
    logic [CNT_W-1:0]   clrCntReg;
    logic               clrTimeout;
    logic               chRdy;
    logic [1:0]         errReg;

    logic [31:0]        dataReg, dataNext;
    logic               validReg, validNext;
    logic               busyReg, busyNext;
    logic [1:0]         pulseReg, pulseNext;

    logic               accept;

    assign rdyVec = {iRdy2, iRdy1};
    assign accept = validReg && iREADY;

    // A channel is re-armed only while its ready flag is low, so a lock that
    // never released cannot be sent a second time.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : gChan
            assign eligible[gi]  = rdyVec[gi] && armedReg[gi] && iEN;
            assign armedNext[gi] = (grantNow && grant[gi]) ? 1'b0 :
                                   (!rdyVec[gi])           ? 1'b1 :
                                                             armedReg[gi];
        end
    endgenerate

    rr_arb2 uArb (
        .iCLK     (iCLK),
        .iRSTn    (iRSTn),
        .iReq     (eligible),
        .iAdvance (grantNow),
        .oGrant   (grant)
    );

    assign grantNow   = (stateReg == ST_IDLE) && (eligible != 2'b00);
    assign chRdy      = |(chReg & rdyVec);
    assign clrTimeout = (clrCntReg >= CNT_W'(pCLR_TIMEOUT));
    assign seqWide    = 16'(seqReg);
    // In IDLE the header is being prepared for the channel just granted.
    assign chSel      = (stateReg == ST_IDLE) ? grant : chReg;

    // ---------------------------------------------------------------- state register
    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            stateReg <= ST_IDLE;
        end else begin
            stateReg <= stateNext;
        end
    end

    // ---------------------------------------------------------------- next state
    always_comb begin
        stateNext = stateReg;
        unique case (stateReg)
            ST_IDLE: if (eligible != 2'b00) stateNext = ST_HDR;
            ST_HDR:  if (accept)            stateNext = ST_LO;
            ST_LO:   if (accept)            stateNext = ST_HI;
            ST_HI:   if (accept)            stateNext = ST_ACK;
            ST_ACK:                         stateNext = ST_CLR;
            ST_CLR:  if (!chRdy || clrTimeout) stateNext = ST_IDLE;
            default:                        stateNext = ST_IDLE;
        endcase
    end

    // ---------------------------------------------------------------- outputs
    // Outputs are registered, so their next values are decoded from stateNext.
    // While a word is stalled, stateNext == stateReg and the sources (snapshot,
    // sequence, channel id) are unchanged, so oDATA holds.
    always_comb begin
        dataNext  = 32'h0;
        validNext = 1'b0;
        busyNext  = (stateNext != ST_IDLE);
        pulseNext = 2'b00;
        unique case (stateNext)
            ST_HDR: begin
                validNext = 1'b1;
                dataNext  = makeHeader(chSel, seqWide);
            end
            ST_LO: begin
                validNext = 1'b1;
                dataNext  = snapReg[31:0];
            end
            ST_HI: begin
                validNext = 1'b1;
                dataNext  = snapReg[63:32];
            end
            ST_ACK:  pulseNext = chReg;
            default: ;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            dataReg  <= 32'h0;
            validReg <= 1'b0;
            busyReg  <= 1'b0;
            pulseReg <= 2'b00;
        end else begin
            dataReg  <= dataNext;
            validReg <= validNext;
            busyReg  <= busyNext;
            pulseReg <= pulseNext;
        end
    end

    // ---------------------------------------------------------------- datapath
    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            armedReg  <= 2'b11;
            chReg     <= 2'b00;
            snapReg   <= 64'h0;
            seqReg    <= '0;
            clrCntReg <= '0;
            errReg    <= 2'b00;
        end else begin
            armedReg <= armedNext;

            if (grantNow) begin
                chReg   <= grant;
                snapReg <= grant[0] ? {i1Hi, i1Lo} : {i2Hi, i2Lo};
            end

            // Sequence advances only once the whole frame has been accepted.
            if ((stateReg == ST_HI) && accept) begin
                seqReg <= seqReg + pSEQ_W'(1);
            end

            // Counter holds the number of CLR cycles including the current one.
            if (stateReg == ST_ACK) begin
                clrCntReg <= CNT_W'(1);
            end else if ((stateReg == ST_CLR) && !clrTimeout) begin
                clrCntReg <= clrCntReg + CNT_W'(1);
            end

            if ((stateReg == ST_CLR) && chRdy && clrTimeout) begin
                errReg <= errReg | chReg;
            end
        end
    end

    assign oDATA        = dataReg;
    assign oVALID       = validReg;
    assign oBUSY        = busyReg;
    assign oResetLatch1 = pulseReg[0];
    assign oResetLatch2 = pulseReg[1];
    assign oERR         = errReg;

endmodule
